// File: rtl/svn_seg_scan.sv
// svn_seg_scan: 3-digit multiplexed 7-segment hex display driver
// with a one-entry input buffer committed only at frame boundaries.
module svn_seg_scan #(
  parameter int   CLK_IN_MHZ   = 125,
  parameter logic LED_POLARITY = 1'b0,
  parameter logic SEL_POLARITY = 1'b1,
  parameter int   SCAN_HZ      = 1000,
  parameter int   BLANK_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [11:0] data_i,
  input  logic [2:0]  dp_i,
  input  logic        lzb_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  display_o,
  output logic [2:0]  seg_sel_o,
  output logic        frame_o
);

`ifdef SIM
  localparam int SCAN_TICKS = 8;
`else
  localparam int SCAN_TICKS = (CLK_IN_MHZ * 1000000) / (SCAN_HZ * 3);
`endif

  localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);
  localparam logic [7:0] DISP_OFF = {8{~LED_POLARITY}};
  localparam logic [2:0] SEL_OFF  = {3{~SEL_POLARITY}};

  generate
    if (BLANK_CYCLES >= SCAN_TICKS) begin : g_bad_blank
      $error("BLANK_CYCLES must be smaller than SCAN_TICKS");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  logic [11:0]   r_act_data;
  logic [2:0]    r_act_dp;
  logic          r_act_lzb;
  logic [11:0]   r_buf_data;
  logic [2:0]    r_buf_dp;
  logic          r_buf_lzb;
  logic          r_full;
  logic [7:0]    r_disp;
  logic [2:0]    r_sel;
  logic          r_frame;

  logic          w_wrap;
  logic          w_fwrap;
  logic          w_accept;
  logic          w_drive;
  logic [3:0]    w_nib;
  logic          w_dp;
  logic          w_blank;
  logic          w_blank2;
  logic          w_blank1;
  logic [6:0]    w_hex;
  logic [7:0]    w_pat;
  logic [2:0]    w_onehot;

  assign w_wrap   = (r_cnt == LAST);
  assign w_fwrap  = w_wrap && (r_dig == 2'd2);
  assign w_accept = valid_i && !r_full;
  assign w_drive  = !(r_cnt < BLK);
  assign w_blank2 = r_act_lzb && (r_act_data[11:8] == 4'h0);
  assign w_blank1 = w_blank2 && (r_act_data[7:4] == 4'h0);
  assign w_onehot = 3'b001 << r_dig;

  // Slot counter and digit index; the digit advances on each slot wrap.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
      r_dig <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_dig <= (r_dig == 2'd2) ? 2'd0 : r_dig + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pending buffer fills on handshake; it drains into the active value
  // only at the digit 2 -> 0 wrap so a frame never mixes two values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_act_lzb  <= 1'b0;
      r_buf_data <= '0;
      r_buf_dp   <= '0;
      r_buf_lzb  <= 1'b0;
      r_full     <= 1'b0;
    end else if (w_fwrap && r_full) begin
      r_act_data <= r_buf_data;
      r_act_dp   <= r_buf_dp;
      r_act_lzb  <= r_buf_lzb;
      r_full     <= 1'b0;
    end else if (w_accept) begin
      r_buf_data <= data_i;
      r_buf_dp   <= dp_i;
      r_buf_lzb  <= lzb_i;
      r_full     <= 1'b1;
    end
  end

  // Select the nibble, dp bit and blanking state of the scanned digit.
  always_comb begin
    w_nib   = r_act_data[3:0];
    w_dp    = r_act_dp[0];
    w_blank = 1'b0;
    case (r_dig)
      2'd1: begin
        w_nib   = r_act_data[7:4];
        w_dp    = r_act_dp[1];
        w_blank = w_blank1;
      end
      2'd2: begin
        w_nib   = r_act_data[11:8];
        w_dp    = r_act_dp[2];
        w_blank = w_blank2;
      end
      default: begin
        w_nib   = r_act_data[3:0];
        w_dp    = r_act_dp[0];
        w_blank = 1'b0;
      end
    endcase
  end

  // Active-high hex to {g..a} segment lookup.
  always_comb begin
    w_hex = 7'h00;
    case (w_nib)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
      default: w_hex = 7'h00;
    endcase
  end

  assign w_pat = {w_dp, (w_blank ? 7'h00 : w_hex)};

  // Registered outputs: blank phase turns everything off to stop ghosting.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_disp  <= DISP_OFF;
      r_sel   <= SEL_OFF;
      r_frame <= 1'b0;
    end else begin
      r_disp  <= w_drive ? (w_pat ^ DISP_OFF) : DISP_OFF;
      r_sel   <= w_drive ? (w_onehot ^ SEL_OFF) : SEL_OFF;
      r_frame <= (r_cnt == '0) && (r_dig == 2'd0);
    end
  end

  assign ready_o   = !r_full;
  assign display_o = r_disp;
  assign seg_sel_o = r_sel;
  assign frame_o   = r_frame;

endmodule

// File: tb/tb_svn_seg_scan.sv
// tb_svn_seg_scan: directed bench for svn_seg_scan with a slot
// scoreboard fed by the stimulus and drained by an output monitor.
module tb_svn_seg_scan;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] disp;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [11:0] data;
  logic [2:0]  dp;
  logic        lzb;
  logic        valid;
  logic        ready;
  logic [7:0]  disp;
  logic [2:0]  sel;
  logic        frame;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  bit   mon_done = 1'b0;

  svn_seg_scan #(
    .CLK_IN_MHZ  (1),
    .LED_POLARITY(1'b0),
    .SEL_POLARITY(1'b1),
    .SCAN_HZ     (41666),
    .BLANK_CYCLES(2)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .data_i   (data),
    .dp_i     (dp),
    .lzb_i    (lzb),
    .valid_i  (valid),
    .ready_o  (ready),
    .display_o(disp),
    .seg_sel_o(sel),
    .frame_o  (frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic push_frame(input logic [7:0] d0,
                            input logic [7:0] d1,
                            input logic [7:0] d2);
    q.push_back(exp_t'{sel: 3'b001, disp: d0});
    q.push_back(exp_t'{sel: 3'b010, disp: d1});
    q.push_back(exp_t'{sel: 3'b100, disp: d2});
  endtask

  task automatic send(input logic [11:0] d,
                      input logic [2:0] p,
                      input logic z);
    bit acc;
    acc   = 1'b0;
    data  = d;
    dp    = p;
    lzb   = z;
    valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      acc = ready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    chk("send_accept", {31'd0, acc}, 32'd1);
    #1 valid = 1'b0;
  endtask

  task automatic wait_frame();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (frame) begin
        got = 1'b1;
        break;
      end
    end
    chk("frame_seen", {31'd0, got}, 32'd1);
  endtask

  logic [2:0] prev_sel = 3'b000;
  int   blank_run = 0;
  int   drive_run = 0;
  int   since_frame = 99;
  exp_t cur = '0;

  // Output monitor: checks slot timing and pops one expectation per slot.
  always @(negedge clk) begin
    if (mon_done) begin
      prev_sel = sel;
    end else if (!rstn) begin
      prev_sel    = 3'b000;
      blank_run   = 0;
      drive_run   = 0;
      since_frame = 99;
    end else begin
      since_frame++;
      if (frame) begin
        since_frame = 0;
        chk("frame_in_blank", {29'd0, sel}, 32'd0);
      end
      if (sel == 3'b000) begin
        chk("blank_disp", {24'd0, disp}, 32'hFF);
        if (prev_sel != 3'b000) begin
          chk("drive_len", drive_run, 6);
          blank_run = 1;
        end else begin
          blank_run++;
        end
        drive_run = 0;
      end else if (prev_sel == 3'b000) begin
        chk("blank_len", blank_run, 2);
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL slot_unexpected: sel %b disp %h, none queued",
                   sel, disp);
          cur = exp_t'{sel: sel, disp: disp};
        end else begin
          cur = q.pop_front();
          chk("slot_sel", {29'd0, sel}, {29'd0, cur.sel});
          chk("slot_disp", {24'd0, disp}, {24'd0, cur.disp});
          if (cur.sel == 3'b001)
            chk("frame_align", since_frame, 2);
        end
        drive_run = 1;
      end else begin
        chk("hold_sel", {29'd0, sel}, {29'd0, cur.sel});
        chk("hold_disp", {24'd0, disp}, {24'd0, cur.disp});
        drive_run++;
      end
      prev_sel = sel;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn  = 1'b0;
    valid = 1'b0;
    data  = '0;
    dp    = '0;
    lzb   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_disp", {24'd0, disp}, 32'hFF);
    chk("rst_sel", {29'd0, sel}, 32'd0);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);

    push_frame(8'hC0, 8'hC0, 8'hC0);
    push_frame(8'hC0, 8'hC0, 8'hC0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("frame_after_rst", {31'd0, frame}, 32'd1);

    wait_frame();
    push_frame(8'hF8, 8'h08, 8'hB0);
    repeat (5) @(negedge clk);
    send(12'h3A7, 3'b010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ready_low_midframe", {31'd0, ready}, 32'd0);
    end
    wait_frame();
    chk("ready_after_wrap", {31'd0, ready}, 32'd1);

    push_frame(8'h92, 8'hFF, 8'h7F);
    repeat (3) @(negedge clk);
    send(12'h005, 3'b100, 1'b1);
    wait_frame();

    push_frame(8'h86, 8'h99, 8'hC6);
    push_frame(8'h40, 8'h8E, 8'hFF);
    repeat (2) @(negedge clk);
    send(12'hC4E, 3'b000, 1'b0);
    send(12'h0F0, 3'b001, 1'b1);
    @(negedge clk);
    chk("b2b_ready", {31'd0, ready}, 32'd0);
    chk("b2b_at_frame", {31'd0, frame}, 32'd1);

    wait_frame();
    push_frame(8'h40, 8'h8E, 8'hFF);
    push_frame(8'h90, 8'h80, 8'hF8);
    repeat (22) @(negedge clk);
    send(12'h789, 3'b000, 1'b0);
    @(negedge clk);
    chk("wrap_acc_ready", {31'd0, ready}, 32'd0);
    chk("wrap_no_frame", {31'd0, frame}, 32'd0);
    wait_frame();
    chk("wrap_still_pend", {31'd0, ready}, 32'd0);
    wait_frame();
    chk("wrap_drained", {31'd0, ready}, 32'd1);

    repeat (2) @(negedge clk);
    send(12'h0DE, 3'b000, 1'b0);
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (sel == 3'b010) begin
          got = 1'b1;
          break;
        end
      end
      chk("dig1_seen", {31'd0, got}, 32'd1);
    end
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_disp", {24'd0, disp}, 32'hFF);
    chk("arst_sel", {29'd0, sel}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_frame", {31'd0, frame}, 32'd0);
    q.delete();
    push_frame(8'hC0, 8'hC0, 8'hC0);
    push_frame(8'hC0, 8'hC0, 8'hC0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("frame_after_arst", {31'd0, frame}, 32'd1);
    wait_frame();
    wait_frame();
    mon_done = 1'b1;
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
